// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: collects a 2- or 3-byte command frame from RX, runs one
// ALU operation, and returns the 16-bit result to TX as low byte then high byte.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_SIZE    = 16,
  parameter int FUN_SIZE   = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  ALU_EN,
  output logic [FUN_SIZE-1:0]   ALU_FUN,
  output logic [OP_SIZE-1:0]    A,
  output logic [OP_SIZE-1:0]    B,
  input  logic [OP_SIZE-1:0]    ALU_OUT,
  input  logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [FUN_SIZE-1:0] FUN_RSH = FUN_SIZE'(13);
  localparam logic [FUN_SIZE-1:0] FUN_LSH = FUN_SIZE'(14);
  localparam logic [FUN_SIZE-1:0] FUN_BAD = FUN_SIZE'(15);
  // ERR is registered, so the abort decision is taken one cycle early.
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, EXEC, WAIT, SEND_LO, SEND_HI
  } state_t;

  state_t                 state, state_nxt;
  logic [FUN_SIZE-1:0]    fun_q;
  logic [OP_SIZE-1:0]     a_q, b_q, res_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   err_q;

  logic                   ld_fun, ld_a, ld_b, clr_b, cap_res;
  logic                   cnt_clr, cnt_inc, err_set;
  logic [FUN_SIZE-1:0]    fun_in;
  logic [OP_SIZE-1:0]     byte_ext;

  assign fun_in   = RX_P_DATA[FUN_SIZE-1:0];
  assign byte_ext = {{(OP_SIZE-DATA_WIDTH){1'b0}}, RX_P_DATA};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_fun    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    clr_b     = 1'b0;
    cap_res   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          ld_fun = 1'b1;
          if (fun_in == FUN_BAD) err_set   = 1'b1;
          else                   state_nxt = GET_A;
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          ld_a = 1'b1;
          if (fun_q == FUN_RSH || fun_q == FUN_LSH) begin
            clr_b     = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = GET_B;
          end
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          ld_b      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (OUT_VALID) begin
          cap_res   = 1'b1;
          state_nxt = SEND_LO;
        end else if (cnt_q == CNT_LAST) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SEND_LO: if (TX_READY) state_nxt = SEND_HI;
      SEND_HI: if (TX_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fun_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_set;
      if (ld_fun)       fun_q <= fun_in;
      if (ld_a)         a_q   <= byte_ext;
      if (ld_b)         b_q   <= byte_ext;
      else if (clr_b)   b_q   <= '0;
      if (cap_res)      res_q <= ALU_OUT;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    TX_P_DATA = '0;
    case (state)
      SEND_LO: TX_P_DATA = res_q[DATA_WIDTH-1:0];
      SEND_HI: TX_P_DATA = res_q[OP_SIZE-1:DATA_WIDTH];
      default: TX_P_DATA = '0;
    endcase
  end

  assign ALU_EN   = (state == EXEC);
  assign ALU_FUN  = fun_q;
  assign A        = a_q;
  assign B        = b_q;
  assign TX_D_VLD = (state == SEND_LO) || (state == SEND_HI);
  assign BUSY     = (state == EXEC) || (state == WAIT) || TX_D_VLD;
  assign ERR      = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: stimulus queues expected ALU operations and
// TX bytes; a negedge monitor pops and compares them as the DUT presents them.
module tb_alu_cmd_ctrl;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int FW = 4;
  localparam int TO = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          ALU_EN;
  logic [FW-1:0] ALU_FUN;
  logic [OW-1:0] A, B;
  logic [OW-1:0] ALU_OUT = '0;
  logic          OUT_VALID = 1'b0;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_READY = 1'b1;
  logic          BUSY;
  logic          ERR;

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .OP_SIZE(OW), .FUN_SIZE(FW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .A(A), .B(B), .ALU_OUT(ALU_OUT),
    .OUT_VALID(OUT_VALID), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_READY(TX_READY), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [FW-1:0] fun;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
  } op_t;

  op_t           exp_op[$];
  logic [DW-1:0] exp_tx[$];
  op_t           cur_op;
  logic [DW-1:0] cur_tx;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  en_cyc = 0, err_cyc = 0, en_cnt = 0, err_cnt = 0;
  int  byte_cyc = 0;
  bit  withhold = 1'b0;
  int  rdy_mode = 0;
  int  stall = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // ALU model: registered result one cycle after ALU_EN
  always @(posedge CLK) begin
    OUT_VALID <= ALU_EN && !withhold;
    case (ALU_FUN)
      4'd0:    ALU_OUT <= A + B;
      4'd1:    ALU_OUT <= A - B;
      4'd2:    ALU_OUT <= A * B;
      4'd13:   ALU_OUT <= A >> 1;
      4'd14:   ALU_OUT <= A << 1;
      default: ALU_OUT <= '0;
    endcase
  end

  // TX_READY driver: 0 = always ready, 1 = three stall cycles per byte, 2 = never ready
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      1: begin
        if (TX_D_VLD && stall < 3) begin
          TX_READY = 1'b0;
          stall++;
        end else begin
          TX_READY = 1'b1;
          stall = 0;
        end
      end
      2:       TX_READY = 1'b0;
      default: TX_READY = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic stalled_prev = 1'b0, en_prev = 1'b0, vld_prev = 1'b0, err_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge CLK) begin
    if (RST) begin
      stalled_prev = 1'b0;
      en_prev      = 1'b0;
      vld_prev     = 1'b0;
      err_prev     = 1'b0;
    end else begin
      if (ALU_EN) begin
        chk("alu_en_single", {31'd0, en_prev}, 32'd0);
        en_cnt++;
        en_cyc = cyc;
        if (exp_op.size() == 0) begin
          chk("unexpected_alu_en", 32'd1, 32'd0);
        end else begin
          cur_op = exp_op.pop_front();
          chk("alu_fun", {28'd0, ALU_FUN}, {28'd0, cur_op.fun});
          chk("op_a", {16'd0, A}, {16'd0, cur_op.a});
          chk("op_b", {16'd0, B}, {16'd0, cur_op.b});
        end
      end
      if (ERR) begin
        chk("err_single", {31'd0, err_prev}, 32'd0);
        err_cnt++;
        err_cyc = cyc;
      end
      if (stalled_prev) begin
        chk("tx_hold_vld", {31'd0, TX_D_VLD}, 32'd1);
        chk("tx_hold_data", {24'd0, TX_P_DATA}, {24'd0, prev_data});
      end
      if (TX_D_VLD) begin
        chk("busy_during_tx", {31'd0, BUSY}, 32'd1);
        if (!vld_prev) chk("lo_byte_latency", cyc - en_cyc, 32'd2);
      end
      if (TX_D_VLD && TX_READY) begin
        if (exp_tx.size() == 0) begin
          chk("unexpected_tx_byte", {24'd0, TX_P_DATA}, 32'hFFFF_FFFF);
        end else begin
          cur_tx = exp_tx.pop_front();
          chk("tx_byte", {24'd0, TX_P_DATA}, {24'd0, cur_tx});
        end
      end
      stalled_prev = TX_D_VLD && !TX_READY;
      prev_data    = TX_P_DATA;
      en_prev      = ALU_EN;
      vld_prev     = TX_D_VLD;
      err_prev     = ERR;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    byte_cyc  = cyc;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic expect_frame(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] lo, input logic [7:0] hi);
    exp_op.push_back({fun, 8'd0, a, 8'd0, b});
    exp_tx.push_back(lo);
    exp_tx.push_back(hi);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((BUSY || exp_tx.size() != 0 || exp_op.size() != 0) && n < 300);
    chk(name, {31'd0, (BUSY || exp_tx.size() != 0 || exp_op.size() != 0)}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_alu_en"}, {31'd0, ALU_EN}, 32'd0);
    chk({tag, "_alu_fun"}, {28'd0, ALU_FUN}, 32'd0);
    chk({tag, "_a"}, {16'd0, A}, 32'd0);
    chk({tag, "_b"}, {16'd0, B}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, TX_P_DATA}, 32'd0);
    chk({tag, "_tx_vld"}, {31'd0, TX_D_VLD}, 32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n0, k;
    RST       = 1'b1;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // ADD 5 + 3
    e0 = err_cnt;
    expect_frame(4'd0, 8'h05, 8'h03, 8'h08, 8'h00);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h03);
    wait_done("add_done");
    chk("add_no_err", err_cnt, e0);

    // upper command nibble ignored
    expect_frame(4'd0, 8'h10, 8'h20, 8'h30, 8'h00);
    send_byte(8'hA0); send_byte(8'h10); send_byte(8'h20);
    wait_done("nibble_done");

    // MULT 0xFF * 0xFF with TX backpressure
    rdy_mode = 1;
    expect_frame(4'd2, 8'hFF, 8'hFF, 8'h01, 8'hFE);
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
    wait_done("mult_done");
    rdy_mode = 0;

    // 2-byte shift frames
    expect_frame(4'd13, 8'h80, 8'h00, 8'h40, 8'h00);
    send_byte(8'h0D); send_byte(8'h80);
    wait_done("rsh_done");
    expect_frame(4'd14, 8'h80, 8'h00, 8'h00, 8'h01);
    send_byte(8'h0E); send_byte(8'h80);
    wait_done("lsh_done");

    // invalid opcode then a normal frame
    e0 = err_cnt;
    n0 = en_cnt;
    send_byte(8'h0F);
    k = byte_cyc;
    repeat (3) @(negedge CLK);
    chk("bad_op_err_count", err_cnt, e0 + 1);
    chk("bad_op_err_timing", err_cyc, k + 1);
    chk("bad_op_no_alu_en", en_cnt, n0);
    chk("bad_op_busy", {31'd0, BUSY}, 32'd0);
    expect_frame(4'd0, 8'h01, 8'h01, 8'h02, 8'h00);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    wait_done("after_bad_done");

    // timeout with RX bytes injected during WAIT
    withhold = 1'b1;
    e0 = err_cnt;
    n0 = en_cnt;
    exp_op.push_back({4'd0, 16'h0005, 16'h0003});
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h03);
    repeat (2) @(posedge CLK);
    send_byte(8'h0F); send_byte(8'h01); send_byte(8'h02);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (err_cnt == e0 && k < 60);
    chk("timeout_err_count", err_cnt, e0 + 1);
    chk("timeout_err_timing", err_cyc - en_cyc, TO);
    chk("timeout_single_alu_en", en_cnt, n0 + 1);
    withhold = 1'b0;
    wait_done("timeout_idle");
    expect_frame(4'd0, 8'h20, 8'h30, 8'h50, 8'h00);
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h30);
    wait_done("after_timeout_done");

    // reset while stalled in SEND_HI
    exp_op.push_back({4'd0, 16'h0005, 16'h0003});
    exp_tx.push_back(8'h08);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h03);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!TX_D_VLD && k < 30);
    chk("reach_send_lo", {31'd0, TX_D_VLD}, 32'd1);
    rdy_mode = 2;
    @(posedge CLK);
    repeat (2) @(posedge CLK);
    #1;
    e0 = err_cnt;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_outputs_zero("midreset");
    rdy_mode = 0;
    expect_frame(4'd1, 8'h09, 8'h04, 8'h05, 8'h00);
    send_byte(8'h01); send_byte(8'h09); send_byte(8'h04);
    wait_done("after_reset_done");
    chk("reset_no_err", err_cnt, e0);

    repeat (3) @(negedge CLK);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("op_queue_drained", exp_op.size(), 0);
    chk("err_total", err_cnt, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller for the ALU: assembles byte-serial command frames from the UART receive path, drives the ALU operand/function/enable inputs for one operation, waits for the ALU's registered result (`OUT_VALID`), and returns the 16-bit result as two bytes to the UART transmit path over a valid/ready handshake. It sits between `RX` deserialisation and `TX` serialisation in the system, acting as the initiator for the ALU.

## Interface
- `DATA_WIDTH`, 8: width of RX/TX bytes and of each received operand.
- `OP_SIZE`, 16: ALU operand/result width; must equal 2*`DATA_WIDTH`.
- `FUN_SIZE`, 4: ALU function code width.
- `TIMEOUT`, 15: maximum `WAIT` cycles for `OUT_VALID` before abort (≥2).
- `CLK` in 1: single clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `RX_P_DATA` in `DATA_WIDTH`: received byte.
- `RX_D_VLD` in 1: one-cycle pulse qualifying `RX_P_DATA`. There is no backpressure.
- `ALU_EN` out 1: one-cycle ALU execute strobe.
- `ALU_FUN` out `FUN_SIZE`: function code.
- `A`, `B` out `OP_SIZE`: operands, each a zero-extended received byte.
- `ALU_OUT` in `OP_SIZE`: ALU result.
- `OUT_VALID` in 1: ALU result valid.
- `TX_P_DATA` out `DATA_WIDTH`: result byte to transmitter.
- `TX_D_VLD` out 1: `TX_P_DATA` valid. Held until accepted.
- `TX_READY` in 1: transmitter accepts the byte when `TX_D_VLD` & `TX_READY`.
- `BUSY` out 1: high in `EXEC`, `WAIT`, `SEND_LO`, `SEND_HI`.
- `ERR` out 1: one-cycle pulse on invalid opcode or timeout.

## Operation
- Frame format:
  - Byte0 is the command: `ALU_FUN` = byte0[3:0], and byte0[7:4] is ignored.
  - Byte1 is operand A.
  - Byte2 is operand B, present only for functions 0–12.
  - Functions 13 (R_SH) and 14 (L_SH) are 2-byte frames with B = 0.
  - Function 15 is invalid.
- States: `IDLE`, `GET_A`, `GET_B`, `EXEC`, `WAIT`, `SEND_LO`, `SEND_HI`.
- `IDLE`, on `RX_D_VLD`:
  - Latch `ALU_FUN`.
  - If the code is 15, pulse `ERR` and stay in `IDLE`.
  - Otherwise go to `GET_A`.
- `GET_A`, on `RX_D_VLD`: `A` ← {0, byte}. Go to `EXEC` if the code is 13/14 (B ← 0); otherwise go to `GET_B`.
- `GET_B`, on `RX_D_VLD`: `B` ← {0, byte}, then go to `EXEC`.
- `EXEC`: `ALU_EN`=1 for exactly this cycle, then unconditionally go to `WAIT`. The timeout counter is cleared.
- `WAIT`:
  - `ALU_EN`=0. The counter increments each cycle.
  - If `OUT_VALID`=1, capture `ALU_OUT` into the result register and go to `SEND_LO`.
  - If the counter reaches `TIMEOUT` without `OUT_VALID`, pulse `ERR` and go to `IDLE`; no TX bytes are sent.
- `SEND_LO`: `TX_D_VLD`=1 with `TX_P_DATA` = result[7:0]. On `TX_READY`, go to `SEND_HI`.
- `SEND_HI`: `TX_D_VLD`=1 with `TX_P_DATA` = result[15:8]. On `TX_READY`, go to `IDLE`.
- `RX_D_VLD` pulses while `BUSY`=1 are dropped silently; they do not start a new frame.
- `A`, `B`, `ALU_FUN` hold their values after a frame until overwritten by the next frame.
- `OUT_VALID` outside `WAIT` is ignored.

## Timing
- Reset (synchronous, `RST`=1 at an edge): state `IDLE`; the counter and result register are cleared. All outputs read 0 from the following cycle: `ALU_EN`, `ALU_FUN`, `A`, `B`, `TX_P_DATA`, `TX_D_VLD`, `BUSY`, `ERR`.
- Reset mid-operation in any state: the frame is abandoned, and no `ERR` and no TX byte are produced.
- Last operand byte at cycle n:
  - `ALU_EN`=1 at n+1.
  - The ALU presents `OUT_VALID`=1 at n+2, and the result is captured.
  - `TX_D_VLD`=1 with the low byte at n+3.
  - With `TX_READY` tied high, the high byte is at n+4 and the block is back in `IDLE` at n+5.
- `ERR` for an invalid opcode is asserted the cycle after byte0 is sampled.
- `ERR` for a timeout is asserted `TIMEOUT` cycles after `EXEC`.
- `TX_P_DATA` is stable for as long as `TX_D_VLD`=1 and `TX_READY`=0. `TX_D_VLD` never deasserts before acceptance, except on reset.
- A new frame byte is accepted in `IDLE` on the same cycle the `SEND_HI` transfer completes plus one; there are no turnaround bubbles beyond that.

## Test plan
- ADD: frame 0x00, 0x05, 0x03 with `TX_READY`=1 → `ALU_EN` pulse of one cycle, A=0x0005, B=0x0003; TX bytes 0x08 then 0x00; `ERR` never asserted.
- MULT with backpressure: frame 0x02, 0xFF, 0xFF with `TX_READY` low for 3 cycles per byte → 0x01 then 0xFE. `TX_P_DATA` and `TX_D_VLD` are held steady while stalled; `BUSY` is high throughout.
- Shift 2-byte frame: 0x0D, 0x80 → B=0, TX bytes 0x40, 0x00. A following 0x0E, 0x80 → 0x00, 0x01.
- Invalid opcode: byte 0x0F → `ERR` pulse, no `ALU_EN`. The next bytes 0x00, 0x01, 0x01 complete normally with result 0x02, 0x00.
- Timeout and dropped bytes:
  - The ALU model withholds `OUT_VALID` → `ERR` after `TIMEOUT` cycles and no TX bytes; the block then accepts a new frame.
  - RX pulses injected during `WAIT` are ignored.
- Reset mid-`SEND_HI` (`TX_READY`=0) → all outputs 0 the next cycle and state `IDLE`. The next frame 0x01, 0x09, 0x04 returns 0x05, 0x00.
